// File: rtl/product_bcd_converter_pkg.sv
// Shared definitions for the product BCD converter: FSM state encoding and digit width.
package product_bcd_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam int DIGIT_W = 4;

endpackage

// File: rtl/product_bcd_converter_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the next left shift.
module product_bcd_converter_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter for the multiplier product, one input bit per clock.
module product_bcd_converter #(
    parameter int BIN_WIDTH  = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    bin_in,
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd_out
);
    import product_bcd_converter_pkg::*;

    localparam int SCR_W = DIGIT_W * BCD_DIGITS;
    localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_WIDTH - 1);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIN_WIDTH-1:0] bin_q;
    logic [SCR_W-1:0]     scr_q;
    logic [SCR_W-1:0]     bcd_q;
    logic                 done_q;

    logic [SCR_W-1:0]     scr_corr;
    logic [SCR_W-1:0]     scr_d;
    logic [BIN_WIDTH-1:0] bin_d;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        product_bcd_converter_add3 u_add3 (
            .digit_i (scr_q[g*DIGIT_W +: DIGIT_W]),
            .digit_o (scr_corr[g*DIGIT_W +: DIGIT_W])
        );
    end

    // The binary MSB enters the ones digit as the corrected scratch shifts left.
    assign {scr_d, bin_d} = {scr_corr, bin_q} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        bin_q   <= bin_in;
                        scr_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    scr_q <= scr_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        bcd_q   <= scr_d;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready   = (state_q != ST_SHIFT);
    assign busy    = (state_q == ST_SHIFT);
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule
